// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores feed a TX FIFO drained by an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic        i_storeReq,
    input  logic        i_loadReq,
    input  logic        i_addr,
    input  logic [31:0] i_dataIn,
    output logic [31:0] o_dataOut,
    output logic        o_tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_ovf;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic [31:0]   r_data_out;

    state_t        w_state_n;
    logic [BW-1:0] w_baud_n;
    logic [2:0]    w_bit_n;
    logic [7:0]    w_shift_n;
    logic          w_tx_n;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_evt;
    logic          w_status_rd;
    logic          w_baud_done;
    logic [7:0]    w_head;
    logic          w_unused;

    assign w_unused    = ^i_dataIn[31:8];
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_busy      = !((r_state == StIdle) && w_empty);
    assign w_push_req  = i_sel & i_storeReq & ~i_addr;
    // Full is judged before any same-cycle pop, so a push at full is always dropped.
    assign w_push      = w_push_req & ~w_full;
    assign w_ovf_evt   = w_push_req & w_full;
    assign w_status_rd = i_sel & i_loadReq & i_addr;
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_dataIn[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_status_rd) begin
                r_ovf <= 1'b0;
            end
            if (i_sel && i_loadReq) begin
                r_data_out <= i_addr ? {28'd0, r_ovf, w_empty, w_busy, w_full} : 32'd0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_baud    <= w_baud_n;
            r_bit_idx <= w_bit_n;
            r_shift   <= w_shift_n;
            r_tx      <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit_idx;
        w_shift_n = r_shift;
        w_tx_n    = 1'b1;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = StStart;
                end
            end
            StStart: begin
                w_tx_n = 1'b0;
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_state_n = StData;
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            StData: begin
                w_tx_n = r_shift[0];
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    w_bit_n   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = StParity;
`else
                        w_state_n = StStop;
`endif
                    end
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                w_tx_n = r_parity;
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_state_n = StStop;
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
`endif
            StStop: begin
                w_tx_n = 1'b1;
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_state_n = StIdle;
                end else begin
                    w_baud_n = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_n = StIdle;
            end
        endcase
    end

    assign o_tx      = r_tx;
    assign o_dataOut = r_data_out;
endmodule
